// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment driver with shadowed, frame-synchronous display updates.
// Outputs are registered one cycle after the scan state; no backpressure, load is always accepted.
module sevenseg_scan #(
   parameter int NUM_DIGITS      = 4,
   parameter int TICKS_PER_DIGIT = 100000,
   parameter int DEAD_TICKS      = 1,
   parameter int ACTIVE_LOW      = 1,
   parameter int LZ_SUPPRESS     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int TW = $clog2(TICKS_PER_DIGIT);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
   localparam logic [TW-1:0] TICK_DEAD  = TW'(DEAD_TICKS);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [TW-1:0]           tick_q, tick_d;
   logic [DW-1:0]           digit_q, digit_d;
   logic                    wrap_q, wrap_d;
   logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
   logic                    pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    frame_done_q, frame_done_d;

   logic                    tick_term;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_blank, lz_blank, dark;
   logic [NUM_DIGITS-1:0]   an_act;
   logic [6:0]              seg_act;
   logic                    dp_act;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // Scan position and frame wrap detection.
   always_comb begin
      tick_term = (tick_q == TICK_LAST);
      wrap_d    = enable && tick_term && (digit_q == DIGIT_LAST);
      tick_d    = tick_q;
      digit_d   = digit_q;
      if (enable) begin
         if (tick_term) begin
            tick_d  = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
         end else begin
            tick_d = tick_q + TW'(1);
         end
      end
   end

   // Shadow capture; the display copy only changes at a frame wrap so a frame never tears.
   always_comb begin
      sh_val_d     = sh_val_q;
      sh_dp_d      = sh_dp_q;
      sh_blank_d   = sh_blank_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      disp_blank_d = disp_blank_q;
      pending_d    = pending_q;
      if (load) begin
         sh_val_d   = value;
         sh_dp_d    = dp_in;
         sh_blank_d = blank_in;
         pending_d  = 1'b1;
      end
      if (wrap_d) begin
         disp_val_d   = sh_val_d;
         disp_dp_d    = sh_dp_d;
         disp_blank_d = sh_blank_d;
         pending_d    = 1'b0;
      end
   end

   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (DW'(k) == digit_q) begin
            cur_nib   = disp_val_q[4*k +: 4];
            cur_dp    = disp_dp_q[k];
            cur_blank = disp_blank_q[k];
         end
      end
      // A digit is a leading zero when it and every more-significant nibble are zero.
      lz_blank = 1'b0;
      if ((LZ_SUPPRESS != 0) && (digit_q != '0)) begin
         lz_blank = 1'b1;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((DW'(k) >= digit_q) && (disp_val_q[4*k +: 4] != 4'h0)) begin
               lz_blank = 1'b0;
            end
         end
      end
      dark = cur_blank || lz_blank;
   end

   always_comb begin
      an_act  = '0;
      seg_act = '0;
      dp_act  = 1'b0;
      if (enable) begin
         seg_act = dark ? 7'b0 : hex_to_seg(cur_nib);
         dp_act  = !dark && cur_dp;
         if (tick_q >= TICK_DEAD) begin
            an_act = NUM_DIGITS'(1) << digit_q;
         end
      end
      an_d         = an_act ^ {NUM_DIGITS{POL}};
      seg_d        = seg_act ^ {7{POL}};
      dp_d         = dp_act ^ POL;
      frame_done_d = wrap_q && enable;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q       <= '0;
         digit_q      <= '0;
         wrap_q       <= 1'b0;
         sh_val_q     <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '0;
         pending_q    <= 1'b0;
         an_q         <= {NUM_DIGITS{POL}};
         seg_q        <= {7{POL}};
         dp_q         <= POL;
         frame_done_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         digit_q      <= digit_d;
         wrap_q       <= wrap_d;
         sh_val_q     <= sh_val_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         disp_blank_q <= disp_blank_d;
         pending_q    <= pending_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: two instances (leading-zero suppression off/on) against a frame-level model.
module tb_sevenseg_scan;
   localparam int N = 4;
   localparam int T = 4;
   localparam int D = 1;
   localparam int FRAME = N * T;

   logic          clk = 1'b0;
   logic          reset, enable, load;
   logic [15:0]   value;
   logic [3:0]    dp_in, blank_in;
   logic [6:0]    seg0, seg1;
   logic          dp0, dp1, fd0, fd1, pend0, pend1;
   logic [3:0]    an0, an1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sevenseg_scan #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .DEAD_TICKS(D),
                   .ACTIVE_LOW(1), .LZ_SUPPRESS(0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_in(blank_in), .seg(seg0), .dp(dp0), .an(an0),
      .frame_done(fd0), .pending(pend0));

   sevenseg_scan #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .DEAD_TICKS(D),
                   .ACTIVE_LOW(1), .LZ_SUPPRESS(1)) dut_lz (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_in(blank_in), .seg(seg1), .dp(dp1), .an(an1),
      .frame_done(fd1), .pending(pend1));

   wire [27:0] got_vec = {an0, seg0, dp0, fd0, pend0, an1, seg1, dp1, fd1, pend1};

   function automatic logic [6:0] seg_code(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0111111;  4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;  4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;  4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;  4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;  4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;  4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;  4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;  default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // Frame-level model: pos is the cycle offset inside a frame; the shown value changes only at frame start.
   int          pos;
   logic [15:0] m_sh_val, m_val;
   logic [3:0]  m_sh_dp, m_dp, m_sh_bl, m_bl;
   bit          m_pend, m_prev_wrap;
   logic [27:0] exp_vec;

   always @(posedge clk) begin
      int d, t;
      logic [3:0] nib, e_an;
      logic [6:0] e_seg0, e_seg1;
      logic dark0, dark1, e_dp0, e_dp1, e_fd;
      bit wrap;
      if (reset) begin
         pos = 0; m_sh_val = 0; m_val = 0; m_sh_dp = 0; m_dp = 0; m_sh_bl = 0; m_bl = 0;
         m_pend = 0; m_prev_wrap = 0;
         exp_vec = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
      end else begin
         d = pos / T;
         t = pos % T;
         nib = m_val[4*d +: 4];
         dark0 = m_bl[d];
         dark1 = m_bl[d] || (d > 0 && (m_val >> (4*d)) == 16'h0);
         e_an   = (enable && t >= D) ? ~(4'b0001 << d) : 4'hF;
         e_seg0 = (enable && !dark0) ? ~seg_code(nib) : 7'h7F;
         e_seg1 = (enable && !dark1) ? ~seg_code(nib) : 7'h7F;
         e_dp0  = !(enable && !dark0 && m_dp[d]);
         e_dp1  = !(enable && !dark1 && m_dp[d]);
         e_fd   = m_prev_wrap && enable;
         wrap = enable && (pos == FRAME - 1);
         if (enable) pos = (pos + 1) % FRAME;
         if (load) begin
            m_sh_val = value; m_sh_dp = dp_in; m_sh_bl = blank_in; m_pend = 1;
         end
         if (wrap) begin
            m_val = m_sh_val; m_dp = m_sh_dp; m_bl = m_sh_bl; m_pend = 0;
         end
         m_prev_wrap = wrap;
         exp_vec = {e_an, e_seg0, e_dp0, e_fd, m_pend, e_an, e_seg1, e_dp1, e_fd, m_pend};
      end
   end

   task test_reset;
      reset = 1; enable = 0; load = 0; value = 0; dp_in = 0; blank_in = 0;
      repeat (2) @(negedge clk);
      total++;
      if (got_vec !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_state got=%b want all-inactive", got_vec);
      end
      total++;
      if (got_vec !== exp_vec) begin
         bad++; $display("FAIL reset_model got=%b exp=%b", got_vec, exp_vec);
      end
      reset = 0;
   endtask

   task test_scan;
      logic [3:0] an_seq [8];
      int fd_first, fd_second;
      an_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
      fd_first = -1; fd_second = -1;
      enable = 1;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL scan_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         if (i < 8) begin
            total++;
            if (an0 !== an_seq[i]) begin
               bad++; $display("FAIL scan_anode i=%0d got=%b want=%b", i, an0, an_seq[i]);
            end
         end
         if (an0 !== 4'hF) begin
            total++;
            if (seg0 !== 7'b1000000) begin
               bad++; $display("FAIL scan_zero i=%0d got=%b want=1000000", i, seg0);
            end
         end
         if (fd0 === 1'b1) begin
            if (fd_first < 0) fd_first = i;
            else if (fd_second < 0) fd_second = i;
         end
      end
      total++;
      if (fd_first < 0 || fd_second - fd_first != FRAME) begin
         bad++; $display("FAIL frame_period first=%0d second=%0d want spacing %0d", fd_first, fd_second, FRAME);
      end
   endtask

   task test_load_midframe;
      logic [6:0] want;
      bit seen_clear, committed;
      repeat (5) @(negedge clk);
      load = 1; value = 16'h9ABF; dp_in = 0; blank_in = 0;
      @(negedge clk);
      load = 0;
      total++;
      if (pend0 !== 1'b1) begin
         bad++; $display("FAIL load_pending got=%b want=1", pend0);
      end
      seen_clear = 0; committed = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL load_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         if (an0 !== 4'hF && (pend0 === 1'b1 || !seen_clear)) begin
            total++;
            if (seg0 !== 7'b1000000) begin
               bad++; $display("FAIL load_old i=%0d got=%b want=1000000", i, seg0);
            end
         end else if (an0 !== 4'hF && seen_clear) begin
            case (an0)
               4'b1110: want = 7'b0001110;
               4'b1101: want = 7'b0000011;
               4'b1011: want = 7'b0001000;
               default: want = 7'b0010000;
            endcase
            committed = 1;
            total++;
            if (seg0 !== want) begin
               bad++; $display("FAIL load_new an=%b got=%b want=%b", an0, seg0, want);
            end
         end
         seen_clear = (pend0 === 1'b0);
      end
      total++;
      if (!committed) begin
         bad++; $display("FAIL load_commit got=never want=committed within 40 cycles");
      end
   endtask

   task test_double_load;
      bit found;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (pos == 1) found = 1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL dbl_align got=timeout want=frame position 1");
      end
      load = 1; value = 16'h1111;
      @(negedge clk);
      load = 0;
      repeat (2) @(negedge clk);
      load = 1; value = 16'h2222;
      @(negedge clk);
      load = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL dbl_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         if (an0 !== 4'hF) begin
            total++;
            if (seg0 === ~seg_code(4'h1)) begin
               bad++; $display("FAIL dbl_stale i=%0d got=%b (digit 1) want not 1", i, seg0);
            end
         end
      end
   endtask

   task test_load_at_wrap;
      bit found;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (pos == FRAME - 1) found = 1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL wrap_align got=timeout want=frame end");
      end
      load = 1; value = 16'h3333;
      @(negedge clk);
      load = 0;
      for (int i = 0; i < 20; i++) begin
         total++;
         if (pend0 !== 1'b0) begin
            bad++; $display("FAIL wrap_pending i=%0d got=%b want=0", i, pend0);
         end
         if (i > 0 && an0 !== 4'hF) begin
            total++;
            if (seg0 !== ~seg_code(4'h3)) begin
               bad++; $display("FAIL wrap_show i=%0d got=%b want=%b", i, seg0, ~seg_code(4'h3));
            end
         end
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL wrap_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         @(negedge clk);
      end
   endtask

   task test_lz_dp_blank;
      bit seen2, seen3;
      seen2 = 0; seen3 = 0;
      load = 1; value = 16'h0050; dp_in = 0; blank_in = 0;
      @(negedge clk);
      load = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL lz_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         if (i >= 34 && an1 !== 4'hF) begin
            if (an1 == 4'b1011) seen2 = 1;
            if (an1 == 4'b0111) seen3 = 1;
            total++;
            if ((an1 == 4'b1011 || an1 == 4'b0111) && seg1 !== 7'h7F) begin
               bad++; $display("FAIL lz_blank an=%b got=%b want=1111111", an1, seg1);
            end else if (an1 == 4'b1110 && seg1 !== 7'b1000000) begin
               bad++; $display("FAIL lz_digit0 got=%b want=1000000", seg1);
            end else if (an1 == 4'b1101 && seg1 !== ~seg_code(4'h5)) begin
               bad++; $display("FAIL lz_digit1 got=%b want=%b", seg1, ~seg_code(4'h5));
            end
         end
      end
      total++;
      if (!(seen2 && seen3)) begin
         bad++; $display("FAIL lz_strobe got=%b%b want=11 (anodes 2,3 strobed)", seen2, seen3);
      end
      load = 1; value = 16'h1234; dp_in = 4'b0100; blank_in = 4'b0001;
      @(negedge clk);
      load = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL dpbl_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         if (i >= 34 && an0 !== 4'hF) begin
            total++;
            if (dp0 !== (an0 != 4'b1011)) begin
               bad++; $display("FAIL dp_slot an=%b got=%b want=%b", an0, dp0, an0 != 4'b1011);
            end else if (an0 == 4'b1110 && seg0 !== 7'h7F) begin
               bad++; $display("FAIL blank_digit0 got=%b want=1111111", seg0);
            end
         end
      end
   endtask

   task test_reset_mid;
      repeat (3) @(negedge clk);
      load = 1; value = 16'h8888; dp_in = 4'hF; blank_in = 0;
      @(negedge clk);
      load = 0;
      total++;
      if (pend0 !== 1'b1) begin
         bad++; $display("FAIL rmid_pending got=%b want=1", pend0);
      end
      reset = 1; load = 1; value = 16'h7777;
      @(negedge clk);
      reset = 0; load = 0; dp_in = 0;
      total++;
      if ({an0, seg0, dp0, fd0, pend0} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL rmid_state got=%b want=%b", {an0, seg0, dp0, fd0, pend0}, {4'hF, 7'h7F, 3'b100});
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL rmid_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         if (an0 !== 4'hF) begin
            total++;
            if (seg0 !== 7'b1000000 || pend0 !== 1'b0) begin
               bad++; $display("FAIL rmid_discard got seg=%b pend=%b want seg=1000000 pend=0", seg0, pend0);
            end
         end
      end
   endtask

   task test_random;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL rand_model i=%0d got=%b exp=%b", i, got_vec, exp_vec);
         end
         reset    = ($urandom_range(0, 99) == 0);
         enable   = ($urandom_range(0, 7) != 0);
         load     = ($urandom_range(0, 9) == 0);
         value    = 16'($urandom);
         dp_in    = 4'($urandom);
         blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      end
      reset = 0; load = 0; enable = 1;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load_midframe();
      test_double_load();
      test_load_at_wrap();
      test_lz_dp_blank();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=bench completion");
      $fatal(1, "watchdog expired");
   end
endmodule
